// File: rtl/pio_cmd_responder_if.sv
// PIO command/response word pair between the Nios processor and the fabric responder.
interface pio_cmd_responder_if;
  logic [9:0] pio_cmd_export;
  logic [9:0] pio_rsp_export;

  modport master (output pio_cmd_export, input pio_rsp_export);
  modport slave  (input pio_cmd_export, output pio_rsp_export);
endinterface

// File: rtl/pio_cmd_responder.sv
// Fabric-side responder for the Nios PIO toggle request/acknowledge protocol.
// Optional PIO_CMD_SYNC_EN: 2-flop synchronizer on the command word for a foreign clock domain.
module pio_cmd_responder #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RESP_LATENCY = 0
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  pio_cmd_responder_if.slave  pio,
  output logic [6:0]          user_out,
  output logic                busy,
  output logic [5:0]          fifo_count
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          HAS_LAT = (RESP_LATENCY > 0);
  localparam logic [7:0]  LAT_M1  = HAS_LAT ? 8'(RESP_LATENCY - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, ACK} state_t;
  typedef enum logic [1:0] {OP_SET_OUT, OP_PUSH, OP_POP, OP_STATUS} op_t;

  state_t          state, state_n;
  op_t             op_q;
  logic [6:0]      data_q;
  logic            req_seen;
  logic            err_q;
  logic [7:0]      rdata_q;
  logic [7:0]      cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [5:0]      count;
  logic [6:0]      mem [DEPTH];
  logic [9:0]      cmd_s;
  logic            full, empty, req_new;

`ifdef PIO_CMD_SYNC_EN
  logic [9:0] cmd_meta, cmd_sync;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_meta <= '0;
      cmd_sync <= '0;
    end else begin
      cmd_meta <= pio.pio_cmd_export;
      cmd_sync <= cmd_meta;
    end
  end

  assign cmd_s = cmd_sync;
`else
  assign cmd_s = pio.pio_cmd_export;
`endif

  assign full       = (count == 6'(DEPTH));
  assign empty      = (count == 6'd0);
  assign req_new    = (cmd_s[9] != req_seen);
  assign busy       = (state != IDLE);
  assign fifo_count = count;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_new) state_n = EXEC;
      EXEC: state_n = HAS_LAT ? WAIT : ACK;
      WAIT: if (cnt == 8'd0) state_n = ACK;
      ACK:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Storage array carries no reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk_clk) begin
    if (state == EXEC && op_q == OP_PUSH && !full) mem[wr_ptr] <= data_q;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      req_seen           <= 1'b0;
      op_q               <= OP_SET_OUT;
      data_q             <= '0;
      err_q              <= 1'b0;
      rdata_q            <= '0;
      cnt                <= '0;
      user_out           <= '0;
      pio.pio_rsp_export <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_new) begin
            req_seen <= cmd_s[9];
            op_q     <= op_t'(cmd_s[8:7]);
            data_q   <= cmd_s[6:0];
          end
        end
        EXEC: begin
          cnt     <= LAT_M1;
          err_q   <= 1'b0;
          rdata_q <= '0;
          unique case (op_q)
            OP_SET_OUT: begin
              user_out <= data_q;
              rdata_q  <= {1'b0, data_q};
            end
            OP_PUSH: begin
              if (!full) begin
                wr_ptr  <= wr_ptr + PW'(1);
                count   <= count + 6'd1;
                rdata_q <= {2'b00, count + 6'd1};
              end else begin
                err_q   <= 1'b1;
                rdata_q <= {2'b00, count};
              end
            end
            OP_POP: begin
              if (!empty) begin
                rdata_q <= {1'b0, mem[rd_ptr]};
                rd_ptr  <= rd_ptr + PW'(1);
                count   <= count - 6'd1;
              end else begin
                err_q   <= 1'b1;
              end
            end
            OP_STATUS: rdata_q <= {full, empty, count};
            default: ;
          endcase
        end
        WAIT: cnt <= cnt - 8'd1;
        ACK:  pio.pio_rsp_export <= {req_seen, err_q, rdata_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Randomized scoreboard bench for pio_cmd_responder with a queue-based reference model.
module tb_pio_cmd_responder;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  pio_cmd_responder_if if_m ();
  pio_cmd_responder_if if_l ();

  logic [6:0] uo_m, uo_l;
  logic       busy_m, busy_l;
  logic [5:0] cnt_m, cnt_l;

  pio_cmd_responder #(.DEPTH(DEPTH), .RESP_LATENCY(0)) u_dut (
    .clk_clk(clk), .reset_reset(rst_m), .pio(if_m),
    .user_out(uo_m), .busy(busy_m), .fifo_count(cnt_m));

  pio_cmd_responder #(.DEPTH(DEPTH), .RESP_LATENCY(5)) u_lat (
    .clk_clk(clk), .reset_reset(rst_l), .pio(if_l),
    .user_out(uo_l), .busy(busy_l), .fifo_count(cnt_l));

  typedef struct {
    logic [9:0] rsp;
    logic [6:0] uo;
    logic [5:0] cnt;
  } exp_t;

  exp_t       sbq [$];
  logic [6:0] mdl_q [$];
  logic [6:0] mdl_uo = '0;
  logic       req_m = 1'b0;
  logic       last_ack = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the command's rules to a plain queue and record the expected response.
  task automatic model_push(input logic [1:0] op, input logic [6:0] d);
    exp_t       e;
    logic [7:0] rd = '0;
    logic       er = 1'b0;
    int         sz;
    case (op)
      2'd0: begin mdl_uo = d; rd = {1'b0, d}; end
      2'd1: begin
        if (mdl_q.size() < DEPTH) begin mdl_q.push_back(d); rd = 8'(mdl_q.size()); end
        else begin er = 1'b1; rd = 8'(DEPTH); end
      end
      2'd2: begin
        if (mdl_q.size() > 0) rd = {1'b0, mdl_q.pop_front()};
        else er = 1'b1;
      end
      default: begin
        sz = mdl_q.size();
        rd = 8'(((sz == DEPTH) ? 128 : 0) + ((sz == 0) ? 64 : 0) + sz);
      end
    endcase
    e.rsp = {req_m, er, rd};
    e.uo  = mdl_uo;
    e.cnt = 6'(mdl_q.size());
    sbq.push_back(e);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [6:0] d);
    int n = 0;
    req_m = ~req_m;
    model_push(op, d);
    if_m.pio_cmd_export = {req_m, op, d};
    while (n < 20 && if_m.pio_rsp_export[9] != req_m) begin
      @(negedge clk);
      n++;
    end
    chk("ack_cycles", 32'(n), 32'd3);
  endtask

  always @(negedge clk) begin
    if (!rst_m && if_m.pio_rsp_export[9] != last_ack) begin
      exp_t e;
      last_ack = if_m.pio_rsp_export[9];
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'(if_m.pio_rsp_export), 32'h3ff_ffff);
      end else begin
        e = sbq.pop_front();
        chk("rsp", 32'(if_m.pio_rsp_export), 32'(e.rsp));
        chk("user_out", 32'(uo_m), 32'(e.uo));
        chk("fifo_count", 32'(cnt_m), 32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    if_m.pio_cmd_export = '0;
    if_l.pio_cmd_export = '0;
    repeat (2) @(negedge clk);
    chk("reset_rsp", 32'(if_m.pio_rsp_export), 32'h0);
    chk("reset_busy", 32'(busy_m), 32'h0);
    chk("reset_cnt", 32'(cnt_m), 32'h0);
    rst_m = 1'b0;
    rst_l = 1'b0;
    @(negedge clk);

    // SET_OUT 0x2A with cycle-exact visibility checks
    req_m = 1'b1;
    model_push(2'd0, 7'h2A);
    if_m.pio_cmd_export = 10'h22A;
    @(negedge clk);
    chk("so_busy1", 32'(busy_m), 32'h1);
    chk("so_uo_e0", 32'(uo_m), 32'h0);
    @(negedge clk);
    chk("so_busy2", 32'(busy_m), 32'h1);
    chk("so_uo_e1", 32'(uo_m), 32'h2A);
    chk("so_rsp_e1", 32'(if_m.pio_rsp_export), 32'h0);
    @(negedge clk);
    chk("so_busy3", 32'(busy_m), 32'h0);
    chk("so_rsp_e2", 32'(if_m.pio_rsp_export), 32'h22A);

    do_cmd(2'd3, 7'h00);
    for (int i = 1; i <= 9; i++) do_cmd(2'd1, 7'(i));
    chk("fill_count", 32'(cnt_m), 32'd8);
    do_cmd(2'd3, 7'h00);
    for (int i = 0; i < 3; i++) do_cmd(2'd2, 7'h00);
    for (int i = 9; i <= 11; i++) do_cmd(2'd1, 7'(i));
    for (int i = 0; i < 9; i++) do_cmd(2'd2, 7'h00);
    do_cmd(2'd3, 7'h00);

    // Two further toggles while busy must be dropped; only the first command is acknowledged.
    req_m = ~req_m;
    model_push(2'd0, 7'h11);
    if_m.pio_cmd_export = {req_m, 2'd0, 7'h11};
    @(negedge clk);
    if_m.pio_cmd_export = {~req_m, 2'd1, 7'h22};
    @(negedge clk);
    if_m.pio_cmd_export = {req_m, 2'd0, 7'h55};
    repeat (10) @(negedge clk);
    chk("dbl_uo", 32'(uo_m), 32'h11);
    chk("dbl_pending", 32'(sbq.size()), 32'd0);

    for (int i = 0; i < 100; i++)
      do_cmd(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)));

    // Latency-5 instance: SET_OUT, then reset three edges into a PUSH.
    if_l.pio_cmd_export = 10'h233;
    n = 0;
    while (n < 30 && if_l.pio_rsp_export[9] != 1'b1) begin @(negedge clk); n++; end
    chk("lat_ack_cycles", 32'(n), 32'd8);
    chk("lat_rsp", 32'(if_l.pio_rsp_export), 32'h233);
    chk("lat_uo", 32'(uo_l), 32'h33);
    if_l.pio_cmd_export = 10'h087;
    repeat (4) @(posedge clk);
    chk("lat_noack_pre", 32'(if_l.pio_rsp_export), 32'h233);
    #1 rst_l = 1'b1;
    #1;
    chk("lat_rst_rsp", 32'(if_l.pio_rsp_export), 32'h0);
    chk("lat_rst_cnt", 32'(cnt_l), 32'h0);
    chk("lat_rst_uo", 32'(uo_l), 32'h0);
    chk("lat_rst_busy", 32'(busy_l), 32'h0);
    if_l.pio_cmd_export = 10'h285;
    @(negedge clk);
    chk("lat_rst_hold", 32'(if_l.pio_rsp_export), 32'h0);
    rst_l = 1'b0;
    n = 0;
    while (n < 30 && if_l.pio_rsp_export[9] != 1'b1) begin @(negedge clk); n++; end
    chk("lat_reissue_cycles", 32'(n), 32'd8);
    chk("lat_reissue_rsp", 32'(if_l.pio_rsp_export), 32'h201);
    chk("lat_reissue_cnt", 32'(cnt_l), 32'h1);

    repeat (5) @(negedge clk);
    chk("final_pending", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
